// File: rtl/seg_arb_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
// Holds the requester count, FSM state encoding, idle display values and the lowest-index helper.
package seg_arb_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic {
    S_IDLE,
    S_SHOW
  } state_e;

  localparam logic [15:0] IDLE_NUM = 16'h0000;
  localparam logic [3:0]  IDLE_DOT = 4'hF;

  // Lowest set index of the request mask; only meaningful when the mask is non-zero.
  function automatic logic [1:0] lowest_valid(input logic [NUM_REQ-1:0] mask);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (mask[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_next_pick.sv
// Circular search for the next valid requester after the current owner.
// The owner itself is excluded, so found=0 means no other requester is valid.
module rr_next_pick
  import seg_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [1:0]         owner,
  output logic [1:0]         next_idx,
  output logic               found
);

  logic [1:0] cand;

  // Walk from the farthest candidate back to owner+1 so the nearest one wins.
  always_comb begin
    next_idx = 2'd0;
    found    = 1'b0;
    cand     = 2'd0;
    for (int k = NUM_REQ - 1; k >= 1; k--) begin
      cand = owner + 2'(k);
      if (req_valid[cand]) begin
        next_idx = cand;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin time-sharing of the seven-segment display with requester 0 as a preempting alert.
// All outputs come straight from registers so the scan driver sees one owner per cycle.
module seg_display_arbiter
  import seg_arb_pkg::*;
#(
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int CNT_W        = 26
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [16*NUM_REQ-1:0] req_num,
  input  logic [4*NUM_REQ-1:0] req_dot,
  output logic [15:0]          disp_num,
  output logic [3:0]           dpdot,
  output logic [1:0]           owner,
  output logic                 owner_valid,
  output logic                 switch_pulse
);

  localparam logic [CNT_W-1:0] RELOAD  = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      num_q, num_d;
  logic [3:0]       dot_q, dot_d;
  logic             pulse_q, pulse_d;
  logic             grant;
  logic [1:0]       next_idx;
  logic             found;

  rr_next_pick u_pick (
    .req_valid (req_valid),
    .owner     (owner_q),
    .next_idx  (next_idx),
    .found     (found)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      owner_q <= 2'd0;
      cnt_q   <= '0;
      num_q   <= IDLE_NUM;
      dot_q   <= IDLE_DOT;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      dot_q   <= dot_d;
      pulse_q <= pulse_d;
    end
  end

  // Priority: alert preemption, then owner drop, then dwell expiry, else keep counting.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    grant   = 1'b0;
    num_d   = IDLE_NUM;
    dot_d   = IDLE_DOT;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (|req_valid) begin
          state_d = S_SHOW;
          owner_d = lowest_valid(req_valid);
          grant   = 1'b1;
        end
      end
      S_SHOW: begin
        if (req_valid[0] && owner_q != 2'd0) begin
          owner_d = 2'd0;
          grant   = 1'b1;
        end else if (!req_valid[owner_q]) begin
          if (found) begin
            owner_d = next_idx;
            grant   = 1'b1;
          end else begin
            state_d = S_IDLE;
            owner_d = 2'd0;
            cnt_d   = '0;
            pulse_d = 1'b1;
          end
        end else if (cnt_q == '0) begin
          // A held alert or a lone requester just restarts its dwell without a switch.
          if (owner_q != 2'd0 && found) begin
            owner_d = next_idx;
            grant   = 1'b1;
          end else begin
            cnt_d = RELOAD;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        owner_d = 2'd0;
        cnt_d   = '0;
      end
    endcase

    if (grant) begin
      cnt_d   = RELOAD;
      pulse_d = 1'b1;
    end

    if (state_d == S_SHOW) begin
      num_d = req_num[{owner_d, 4'b0000} +: 16];
      dot_d = req_dot[{owner_d, 2'b00} +: 4];
    end
  end

  assign disp_num     = num_q;
  assign dpdot        = dot_q;
  assign owner        = owner_q;
  assign owner_valid  = (state_q == S_SHOW);
  assign switch_pulse = pulse_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Self-checking bench for seg_display_arbiter: directed scenarios plus random traffic,
// compared every cycle against an owner/age reference model.
module tb_seg_display_arbiter;

  localparam int DWELL = 8;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [63:0] req_num;
  logic [15:0] req_dot;
  logic [15:0] disp_num;
  logic [3:0]  dpdot;
  logic [1:0]  owner;
  logic        owner_valid;
  logic        switch_pulse;

  int errCount;
  int checkCount;

  int          mOwner;
  int          mAge;
  logic [15:0] mNum;
  logic [3:0]  mDot;
  logic        mPulse;

  seg_display_arbiter #(
    .DWELL_CYCLES (DWELL),
    .CNT_W        (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_num      (req_num),
    .req_dot      (req_dot),
    .disp_num     (disp_num),
    .dpdot        (dpdot),
    .owner        (owner),
    .owner_valid  (owner_valid),
    .switch_pulse (switch_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int nextAfter(input logic [3:0] v, input int o);
    for (int k = 1; k < 4; k++) begin
      if (v[(o + k) % 4]) return (o + k) % 4;
    end
    return -1;
  endfunction

  function automatic int lowestSet(input logic [3:0] v);
    for (int i = 0; i < 4; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // Reference model: owner index (-1 when idle) and how many cycles it has been on display.
  task automatic modelStep();
    int prev;
    int nxt;
    int n;
    prev = mOwner;
    nxt  = prev;
    if (!rst_n) begin
      mOwner = -1;
      mAge   = 0;
      mNum   = 16'h0000;
      mDot   = 4'hF;
      mPulse = 1'b0;
      return;
    end
    if (prev < 0) begin
      nxt = lowestSet(req_valid);
      mAge = 1;
    end else if (req_valid[0] && prev != 0) begin
      nxt = 0;
      mAge = 1;
    end else if (!req_valid[prev]) begin
      nxt = nextAfter(req_valid, prev);
      mAge = 1;
    end else if (prev != 0 && mAge == DWELL) begin
      n = nextAfter(req_valid, prev);
      if (n >= 0) nxt = n;
      mAge = 1;
    end else begin
      mAge++;
    end
    mPulse = (nxt != prev);
    mOwner = nxt;
    if (nxt < 0) begin
      mNum = 16'h0000;
      mDot = 4'hF;
    end else begin
      mNum = req_num[16*nxt +: 16];
      mDot = req_dot[4*nxt +: 4];
    end
  endtask

  task automatic applyStimulus(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      modelStep();
      #1;
      checkOutput("owner_valid", 32'(owner_valid), 32'(mOwner >= 0));
      if (mOwner >= 0) checkOutput("owner", 32'(owner), 32'(mOwner));
      checkOutput("disp_num", 32'(disp_num), 32'(mNum));
      checkOutput("dpdot", 32'(dpdot), 32'(mDot));
      checkOutput("switch_pulse", 32'(switch_pulse), 32'(mPulse));
    end
  endtask

  initial begin
    int bound;
    errCount   = 0;
    checkCount = 0;
    mOwner = -1;
    mAge   = 0;
    mNum   = 16'h0;
    mDot   = 4'hF;
    mPulse = 1'b0;
    rst_n     = 1'b0;
    req_valid = 4'h0;
    req_num   = 64'h0;
    req_dot   = 16'hFFFF;

    // Reset held with toggling inputs, then released idle.
    for (int i = 0; i < 3; i++) begin
      req_valid = 4'($urandom);
      req_num   = {$urandom, $urandom};
      req_dot   = 16'($urandom);
      applyStimulus(1);
    end
    req_valid = 4'h0;
    rst_n = 1'b1;
    applyStimulus(4);
    checkOutput("idle_after_reset", 32'(owner_valid), 32'd0);

    // Rotation between owners 1 and 3.
    req_num   = 64'hBEEF_0000_1234_0000;
    req_dot   = 16'h5FAF;
    req_valid = 4'b1010;
    applyStimulus(1);
    checkOutput("t2_first_owner", 32'(owner), 32'd1);
    checkOutput("t2_first_num", 32'(disp_num), 32'h1234);
    applyStimulus(DWELL);
    checkOutput("t2_second_owner", 32'(owner), 32'd3);
    checkOutput("t2_second_num", 32'(disp_num), 32'hBEEF);
    applyStimulus(DWELL);
    checkOutput("t2_third_owner", 32'(owner), 32'd1);

    // Lone requester 2 held across reloads.
    req_num[47:32] = 16'h4242;
    req_valid = 4'b0100;
    applyStimulus(3 * DWELL + 3);
    checkOutput("t3_owner", 32'(owner), 32'd2);

    // Alert preempts owner 3 mid-dwell, then release to owner 1.
    req_valid = 4'b1000;
    applyStimulus(3);
    req_num[15:0] = 16'hDEAD;
    req_valid = 4'b1011;
    applyStimulus(1);
    checkOutput("t4_alert_owner", 32'(owner), 32'd0);
    checkOutput("t4_alert_num", 32'(disp_num), 32'hDEAD);
    applyStimulus(32);
    checkOutput("t4_alert_held", 32'(owner), 32'd0);
    req_valid = 4'b1010;
    applyStimulus(1);
    checkOutput("t4_release_owner", 32'(owner), 32'd1);
    req_valid = 4'b1001;
    applyStimulus(3);
    req_valid = 4'b1000;
    applyStimulus(1);
    checkOutput("t4_release_to3", 32'(owner), 32'd3);

    // Owner drop coinciding with dwell expiry, nobody else valid.
    req_valid = 4'b0010;
    applyStimulus(2);
    bound = 0;
    while (mAge != DWELL && bound < 4 * DWELL) begin
      applyStimulus(1);
      bound++;
    end
    checkOutput("t5_reached_expiry", 32'(bound < 4 * DWELL), 32'd1);
    req_valid = 4'b0000;
    applyStimulus(1);
    checkOutput("t5_idle", 32'(owner_valid), 32'd0);
    checkOutput("t5_pulse", 32'(switch_pulse), 32'd1);
    checkOutput("t5_dot", 32'(dpdot), 32'hF);

    // Live value tracking on the current owner.
    req_num[31:16] = 16'h0001;
    req_valid = 4'b0010;
    applyStimulus(2);
    req_num[31:16] = 16'h0002;
    applyStimulus(1);
    checkOutput("t6_num", 32'(disp_num), 32'h0002);
    checkOutput("t6_no_switch", 32'(switch_pulse), 32'd0);

    // Random traffic with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) req_valid = 4'($urandom);
      if ($urandom_range(0, 3) == 0) req_num = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) req_dot = 16'($urandom);
      rst_n = ($urandom_range(0, 399) != 0);
      applyStimulus(1);
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/seg_display_arbiter.md
# seg_display_arbiter

Time-shares the four-digit seven-segment display between up to four requesters (for example score, lives, level timer and alert code). The block rotates ownership round-robin with a programmable dwell time, and requester 0 acts as an alert that preempts the rotation. It drives the `disp_num`/`dpdot` inputs of the seven-segment scan driver from registered outputs, so the driver always sees a glitch-free, single-owner value.

## Interface
Parameters:
- `DWELL_CYCLES`, default 50_000_000: clk cycles each owner is shown before rotation. Legal range is ≥2.
- `CNT_W`, default 26: width of the dwell counter. Must satisfy 2^CNT_W > DWELL_CYCLES.

Ports:
- `clk`  in  1: system clock. One clock domain; reset is synchronous and active-low.
- `rst_n`  in  1: synchronous, active-low reset.
- `req_valid`  in  4: bit i means requester i has something to show. Bit 0 is the alert.
- `req_num`  in  64: requester i's value in bits [16i+15:16i], as four hex nibbles, digit 0 in the LSBs.
- `req_dot`  in  16: requester i's dot pattern in bits [4i+3:4i]. A 1 turns the dot off (active-low at the segment).
- `disp_num`  out  16: value passed to the scan driver.
- `dpdot`  out  4: dot pattern passed to the scan driver.
- `owner`  out  2: index of the current owner. Meaningful only when `owner_valid`=1.
- `owner_valid`  out  1: 1 when some requester owns the display.
- `switch_pulse`  out  1: one-cycle pulse in the cycle the outputs first show a new owner, including the move into IDLE.

## Operation
- FSM states: IDLE and SHOW.
- IDLE:
  - Outputs `owner_valid`=0, `disp_num`=16'h0000, `dpdot`=4'hF.
  - When any `req_valid` bit is set, grant the lowest valid index and go to SHOW.
- SHOW, evaluated in priority order each cycle:
  1. If `req_valid[0]`=1 and `owner`≠0: preempt to owner 0.
  2. If `req_valid[owner]`=0: move to the next valid index after `owner`, wrapping 3→0. If none is valid, go to IDLE.
  3. If the dwell counter expires and `owner`≠0: move to the next valid index after `owner`. If none other is valid, keep the current owner and reload the counter.
  4. If `owner`=0 and `req_valid[0]`=1: hold indefinitely. Dwell expiry is ignored while the alert is asserted.
- When the alert drops, rule 2 applies: the search starts at index 1.
- The dwell counter loads DWELL_CYCLES−1 on every grant or reload and decrements each cycle in SHOW. Expiry is the cycle the counter equals 0. The counter is held at 0 in IDLE.
- While in SHOW, `disp_num` and `dpdot` track the owner's slice live, registered every cycle, so owner value changes appear with 1-cycle latency.
- Simultaneous events are resolved by the priority order above: alert beats owner-drop, and owner-drop beats expiry.
- Reset has the following behaviour:
  - Reset values: IDLE; `owner`=0; `owner_valid`=0; `disp_num`=0; `dpdot`=4'hF; `switch_pulse`=0; counter=0.
  - Reset asserted mid-dwell abandons the current owner.
  - After reset is released, the first grant follows the IDLE rule, so the lowest valid index wins.

## Timing
- Decisions are made combinationally from state registered at cycle t. The new `owner`, `owner_valid`, `disp_num`, `dpdot` and `switch_pulse` appear at t+1.
- Request→display latency is 1 cycle from IDLE, and 1 cycle for alert preemption.
- An owner keeps the display for exactly DWELL_CYCLES cycles between rotations when other requesters stay valid.
- `switch_pulse` is high for exactly one cycle per owner change and is never high on a reload to the same owner.
- `req_*` inputs are expected to be synchronous to `clk`. No handshake exists; requesters hold `req_valid` for as long as they want display time.

## Structure
- Package `seg_arb_pkg` holds:
  - `NUM_REQ`=4
  - the state enum `{S_IDLE, S_SHOW}`
  - `IDLE_NUM`=16'h0000 and `IDLE_DOT`=4'hF
- Sub-module `rr_next_pick` is purely combinational. Inputs are the `req_valid` mask and `owner`; outputs are `next_idx` and `found`, implementing a circular search starting at `owner`+1. It is reused for both the drop rule and the expiry rule.
- Everything else lives in one file: the FSM, the dwell counter, and the output registers.

## Test plan
Use DWELL_CYCLES=8 for all scenarios.
1. Hold reset for 3 cycles with all inputs toggling, then release with `req_valid`=0. Expect `owner_valid`=0, `disp_num`=0 and `dpdot`=F throughout and after release.
2. Set `req_valid`=4'b1010, `req_num[31:16]`=16'h1234, `req_num[63:48]`=16'hBEEF. Expect owner 1 (1234) one cycle later, owner 3 (BEEF) 8 cycles later, owner 1 again 8 cycles after that. `switch_pulse` is high exactly once per change.
3. Set `req_valid`=4'b0100 only. Expect owner 2 held indefinitely, with counter reloads every 8 cycles and no `switch_pulse` after the first.
4. While owner 3 is mid-dwell, raise `req_valid[0]` with `req_num[15:0]`=16'hDEAD. Expect owner 0 (DEAD) the next cycle, held for 30+ cycles. After `req_valid[0]` drops, expect owner 1 the next cycle if it is valid, else owner 3.
5. Drop `req_valid[owner]` in the same cycle the dwell counter expires, with no other valid requester. Expect IDLE the next cycle, `dpdot`=F and one `switch_pulse`.
6. Change `req_num[31:16]` from 16'h0001 to 16'h0002 while owner 1 is shown. Expect `disp_num` to update after exactly 1 cycle with no owner change.
